// File: rtl/dcache_line_xfer_pkg.sv
// Shared types and default constants for the dcache line transfer engine.
// The state enum, command bytes and line-size helper are used across the slice.
package dcache_line_xfer_pkg;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, DATA, END} xfer_state_t;

    localparam int DEF_LINE_LENGTH  = 4;
    localparam int DEF_PA           = 22;
    localparam int DEF_ADDR_NIBBLES = 6;
    localparam int DEF_READ_WAIT    = 6;

    localparam logic [7:0] DEF_CMD_READ  = 8'hEB;
    localparam logic [7:0] DEF_CMD_WRITE = 8'h38;

    function automatic int line_nibbles(input int line_length);
        return 2 * line_length;
    endfunction

    localparam int LINE_NIBBLES = line_nibbles(DEF_LINE_LENGTH);

endpackage

// File: rtl/dcache_line_xfer_shift_out.sv
// Command/address serializer: loads a wide word and presents its top nibble,
// shifting zeros in so the output settles to 0 once everything has been sent.
module xfer_shift_out
    import dcache_line_xfer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       nibble
);

    logic [WIDTH-1:0] data;

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= value;
        end else if (shift) begin
            data <= {data[WIDTH-5:0], 4'h0};
        end
    end

    assign nibble = data[WIDTH-1 -: 4];

endmodule

// File: rtl/dcache_line_xfer.sv
// Moves one cache line between the dcache nibble port and a quad-nibble serial
// memory: pull fills the cache from memory, push writes a dirty line back.
module dcache_line_xfer
    import dcache_line_xfer_pkg::*;
#(
    parameter int         LINE_LENGTH  = DEF_LINE_LENGTH,
    parameter int         PA           = DEF_PA,
    parameter int         ADDR_NIBBLES = DEF_ADDR_NIBBLES,
    parameter int         READ_WAIT    = DEF_READ_WAIT,
    parameter logic [7:0] CMD_READ     = DEF_CMD_READ,
    parameter logic [7:0] CMD_WRITE    = DEF_CMD_WRITE
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                op_push,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]   tag,
    output logic                                busy,
    output logic                                done,
    output logic [3:0]                          dread,
    output logic                                wstrobe_d,
    input  logic [3:0]                          dwrite,
    output logic                                rstrobe_d,
    output logic                                mem_cs,
    output logic [3:0]                          mem_out,
    output logic                                mem_oe,
    input  logic [3:0]                          mem_in
);

    localparam int OFF_BITS = $clog2(LINE_LENGTH);
    localparam int AW       = ADDR_NIBBLES * 4;
    localparam int SW       = 8 + AW;
    localparam int LN       = line_nibbles(LINE_LENGTH);

    xfer_state_t state, next_state;
    logic [7:0]  count, next_count;
    logic        op_latched, next_push;
    logic        load;
    logic        shift_en;
    logic [3:0]  shift_nibble;
    logic [7:0]  cmd_byte;
    logic [AW-1:0] byte_addr;

    assign cmd_byte  = op_push ? CMD_WRITE : CMD_READ;
    assign byte_addr = AW'({tag, {OFF_BITS{1'b0}}});
    assign shift_en  = (state == CMD) || (state == ADDR);

    xfer_shift_out #(.WIDTH(SW)) u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .shift  (shift_en),
        .value  ({cmd_byte, byte_addr}),
        .nibble (shift_nibble)
    );

    // Each state loads the counter with its length minus one on entry and
    // leaves when it reaches zero.
    always_comb begin
        next_state = state;
        next_count = count;
        next_push  = op_latched;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CMD;
                    next_count = 8'd1;
                    next_push  = op_push;
                    load       = 1'b1;
                end
            end
            CMD: begin
                if (count == 8'd0) begin
                    next_state = ADDR;
                    next_count = 8'(ADDR_NIBBLES - 1);
                end else begin
                    next_count = count - 8'd1;
                end
            end
            ADDR: begin
                if (count == 8'd0) begin
                    if (op_latched) begin
                        next_state = DATA;
                        next_count = 8'(LN - 1);
                    end else begin
                        next_state = WAIT;
                        next_count = 8'(READ_WAIT - 1);
                    end
                end else begin
                    next_count = count - 8'd1;
                end
            end
            WAIT: begin
                if (count == 8'd0) begin
                    next_state = DATA;
                    next_count = 8'(LN - 1);
                end else begin
                    next_count = count - 8'd1;
                end
            end
            DATA: begin
                if (count == 8'd0) begin
                    next_state = END;
                    next_count = 8'd0;
                end else begin
                    next_count = count - 8'd1;
                end
            end
            END: begin
                next_state = IDLE;
                next_count = 8'd0;
            end
            default: begin
                next_state = IDLE;
                next_count = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // register instead of lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 8'd0;
            op_latched <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_cs     <= 1'b0;
            mem_oe     <= 1'b0;
            wstrobe_d  <= 1'b0;
            rstrobe_d  <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            op_latched <= next_push;
            busy       <= (next_state == CMD) || (next_state == ADDR) ||
                          (next_state == WAIT) || (next_state == DATA);
            mem_cs     <= (next_state == CMD) || (next_state == ADDR) ||
                          (next_state == WAIT) || (next_state == DATA);
            done       <= (next_state == END);
            mem_oe     <= (next_state == CMD) || (next_state == ADDR) ||
                          ((next_state == DATA) && next_push);
            wstrobe_d  <= (next_state == DATA) && !next_push;
            rstrobe_d  <= (next_state == DATA) && next_push;
        end
    end

    // dwrite follows the cache offset, so it must pass straight through while
    // the push strobe is high; otherwise the drained shifter supplies zeros.
    assign mem_out = rstrobe_d ? dwrite : shift_nibble;
    assign dread   = wstrobe_d ? mem_in : 4'h0;

endmodule

// File: tb/tb_dcache_line_xfer.sv
// Directed bench for dcache_line_xfer: a cycle-indexed capture of the memory
// pins plus a small cache offset model, checked per scenario.
module tb_dcache_line_xfer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op_push;
    logic [19:0] tag;
    logic        busy;
    logic        done;
    logic [3:0]  dread;
    logic        wstrobe_d;
    logic [3:0]  dwrite;
    logic        rstrobe_d;
    logic        mem_cs;
    logic [3:0]  mem_out;
    logic        mem_oe;
    logic [3:0]  mem_in;

    int checks;
    int errors;

    logic [3:0] o_out [0:39];
    logic [3:0] o_dr  [0:39];
    logic       o_cs  [0:39];
    logic       o_oe  [0:39];
    logic       o_ws  [0:39];
    logic       o_rs  [0:39];
    logic       o_busy[0:39];
    logic       o_done[0:39];
    int         done_cnt;
    int         done_at;
    int         ign_a;
    int         ign_b;

    logic [3:0] push_base;
    logic [2:0] push_off;
    logic [2:0] fill_off;
    logic [3:0] fill [0:7];
    logic [3:0] exp_hdr [0:7];

    dcache_line_xfer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_push   (op_push),
        .tag       (tag),
        .busy      (busy),
        .done      (done),
        .dread     (dread),
        .wstrobe_d (wstrobe_d),
        .dwrite    (dwrite),
        .rstrobe_d (rstrobe_d),
        .mem_cs    (mem_cs),
        .mem_out   (mem_out),
        .mem_oe    (mem_oe),
        .mem_in    (mem_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache side: offsets advance on strobes and fall back to 0 when idle.
    assign dwrite = push_base + {1'b0, push_off};

    always @(posedge clk) begin
        if (rstrobe_d) push_off <= push_off + 3'd1;
        else           push_off <= 3'd0;
        if (wstrobe_d) begin
            fill[fill_off] <= dread;
            fill_off       <= fill_off + 3'd1;
        end else begin
            fill_off <= 3'd0;
        end
    end

    task automatic capture(input bit push, input logic [19:0] t, input logic [3:0] base,
                           input int ncyc, input int reset_at);
        done_cnt = 0;
        done_at  = -1;
        @(posedge clk); #1;
        start   = 1'b1;
        op_push = push;
        tag     = t;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            start   = (k == ign_a) || (k == ign_b);
            op_push = ~push;
            tag     = 20'hABCDE;
            reset   = (k == reset_at);
            mem_in  = (!push && k >= 15 && k <= 22) ? 4'(base + 4'(k - 15)) : 4'h0;
            #1;
            o_out[k]  = mem_out;
            o_dr[k]   = dread;
            o_cs[k]   = mem_cs;
            o_oe[k]   = mem_oe;
            o_ws[k]   = wstrobe_d;
            o_rs[k]   = rstrobe_d;
            o_busy[k] = busy;
            o_done[k] = done;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        start  = 1'b0;
        reset  = 1'b0;
        mem_in = 4'h0;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        start  = 1'b1;
        mem_in = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({busy, done, wstrobe_d, rstrobe_d, mem_cs, mem_oe} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got busy=%b done=%b ws=%b rs=%b cs=%b oe=%b required all 0",
                     busy, done, wstrobe_d, rstrobe_d, mem_cs, mem_oe);
        end
        checks++;
        if (mem_out !== 4'h0 || dread !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_data got mem_out=%h dread=%h required 0 0", mem_out, dread);
        end
        reset = 1'b0;
        start = 1'b0;
        mem_in = 4'h0;
        @(posedge clk); #2;
        checks++;
        if (busy !== 1'b0 || mem_cs !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle got busy=%b cs=%b required 0 0", busy, mem_cs);
        end
    endtask

    task automatic check_header(input string name);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (o_out[k] !== exp_hdr[k-1] || o_oe[k] !== 1'b1 || o_cs[k] !== 1'b1 || o_busy[k] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_hdr cycle %0d got out=%h oe=%b cs=%b busy=%b required out=%h oe=1 cs=1 busy=1",
                         name, k, o_out[k], o_oe[k], o_cs[k], o_busy[k], exp_hdr[k-1]);
            end
        end
    endtask

    task automatic check_pull(input string name, input logic [3:0] base);
        check_header(name);
        for (int k = 9; k <= 14; k++) begin
            checks++;
            if (o_oe[k] !== 1'b0 || o_cs[k] !== 1'b1 || o_ws[k] !== 1'b0 || o_out[k] !== 4'h0) begin
                errors++;
                $display("[TB] FAIL %s_wait cycle %0d got oe=%b cs=%b ws=%b out=%h required 0 1 0 0",
                         name, k, o_oe[k], o_cs[k], o_ws[k], o_out[k]);
            end
        end
        for (int k = 15; k <= 22; k++) begin
            checks++;
            if (o_ws[k] !== 1'b1 || o_rs[k] !== 1'b0 || o_oe[k] !== 1'b0 ||
                o_dr[k] !== 4'(base + 4'(k - 15))) begin
                errors++;
                $display("[TB] FAIL %s_data cycle %0d got ws=%b rs=%b oe=%b dread=%h required 1 0 0 %h",
                         name, k, o_ws[k], o_rs[k], o_oe[k], o_dr[k], 4'(base + 4'(k - 15)));
            end
        end
        checks++;
        if (o_done[23] !== 1'b1 || o_busy[23] !== 1'b0 || o_cs[23] !== 1'b0 || o_ws[23] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_end got done=%b busy=%b cs=%b ws=%b required 1 0 0 0",
                     name, o_done[23], o_busy[23], o_cs[23], o_ws[23]);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 23) begin
            errors++;
            $display("[TB] FAIL %s_latency got done count %0d at cycle %0d required 1 at 23", name, done_cnt, done_at);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (fill[i] !== 4'(base + 4'(i))) begin
                errors++;
                $display("[TB] FAIL %s_fill offset %0d got %h required %h", name, i, fill[i], 4'(base + 4'(i)));
            end
        end
    endtask

    task automatic check_push(input string name, input logic [3:0] base);
        check_header(name);
        for (int k = 9; k <= 16; k++) begin
            checks++;
            if (o_rs[k] !== 1'b1 || o_ws[k] !== 1'b0 || o_oe[k] !== 1'b1 || o_cs[k] !== 1'b1 ||
                o_out[k] !== 4'(base + 4'(k - 9))) begin
                errors++;
                $display("[TB] FAIL %s_data cycle %0d got rs=%b ws=%b oe=%b cs=%b out=%h required 1 0 1 1 %h",
                         name, k, o_rs[k], o_ws[k], o_oe[k], o_cs[k], o_out[k], 4'(base + 4'(k - 9)));
            end
        end
        checks++;
        if (o_rs[8] !== 1'b0 || o_rs[17] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_frame got rs=%b before and %b after data required 0 0", name, o_rs[8], o_rs[17]);
        end
        checks++;
        if (o_done[17] !== 1'b1 || o_busy[17] !== 1'b0 || o_cs[17] !== 1'b0 || done_at !== 17 || done_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL %s_end got done=%b busy=%b cs=%b first done %0d count %0d required 1 0 0 17 1",
                     name, o_done[17], o_busy[17], o_cs[17], done_at, done_cnt);
        end
    endtask

    task automatic test_pull;
        exp_hdr = '{4'hE, 4'hB, 4'h0, 4'h4, 4'h8, 4'hD, 4'h1, 4'h4};
        capture(1'b0, 20'h12345, 4'h1, 26, -1);
        check_pull("pull", 4'h1);
    endtask

    task automatic test_push;
        push_base = 4'h8;
        exp_hdr = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4};
        capture(1'b1, 20'h00001, 4'h0, 22, -1);
        check_push("push", 4'h8);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL push_single_done got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back;
        push_base = 4'h3;
        exp_hdr = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h2, 4'hA, 4'hF, 4'h0};
        capture(1'b1, 20'h00ABC, 4'h0, 17, -1);
        check_push("b2b_push", 4'h3);
        exp_hdr = '{4'hE, 4'hB, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hC};
        capture(1'b0, 20'hFFFFF, 4'h5, 26, -1);
        check_pull("b2b_pull", 4'h5);
    endtask

    task automatic test_start_ignored;
        ign_a = 3;
        ign_b = 10;
        exp_hdr = '{4'hE, 4'hB, 4'h0, 4'h4, 4'h8, 4'hD, 4'h1, 4'h4};
        capture(1'b0, 20'h12345, 4'h7, 30, -1);
        check_pull("ignore", 4'h7);
        checks++;
        if (o_cs[24] !== 1'b0 || o_busy[26] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_idle got cs=%b busy=%b after done required 0 0", o_cs[24], o_busy[26]);
        end
        ign_a = -1;
        ign_b = -1;
    endtask

    task automatic test_reset_mid;
        exp_hdr = '{4'hE, 4'hB, 4'h0, 4'h4, 4'h8, 4'hD, 4'h1, 4'h4};
        capture(1'b0, 20'h12345, 4'h2, 28, 18);
        checks++;
        if (o_ws[18] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_before got ws=%b in 4th data beat required 1", o_ws[18]);
        end
        checks++;
        if (o_cs[19] !== 1'b0 || o_ws[19] !== 1'b0 || o_busy[19] !== 1'b0 || o_oe[19] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_after got cs=%b ws=%b busy=%b oe=%b required 0 0 0 0",
                     o_cs[19], o_ws[19], o_busy[19], o_oe[19]);
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL rst_mid_done got %0d done pulses required 0", done_cnt);
        end
        exp_hdr = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h3, 4'hF, 4'hC, 4'h0};
        capture(1'b0, 20'h00FF0, 4'h9, 26, -1);
        check_pull("rst_rerun", 4'h9);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ign_a     = -1;
        ign_b     = -1;
        reset     = 1'b1;
        start     = 1'b0;
        op_push   = 1'b0;
        tag       = 20'h0;
        mem_in    = 4'h0;
        push_base = 4'h0;
        push_off  = 3'd0;
        fill_off  = 3'd0;
        test_reset();
        test_pull();
        test_push();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
